// File: rtl/scroll_message_loader.sv
// -----------------------------------------------------------------------------
// scroll_message_loader
// Writer side of the scrolling display. Characters chosen on the switches are
// encoded to active-low 7-segment patterns ({g,f,e,d,c,b,a}) and appended to a
// DEPTH-entry buffer on each write key press. A commit publishes the length to
// the scroller, which reads patterns back through a registered read port.
//
// Ports
//   clock       system clock
//   resetb      asynchronous active-low reset
//   char_code   character code to append
//   write_n     append key (raw, active-low)
//   commit_n    commit key (raw, active-low)
//   clear_n     clear key (raw, active-low)
//   rd_addr     scroller read address
//   rd_pattern  registered pattern at rd_addr, blank when outside the message
//   msg_length  committed character count
//   msg_valid   a committed message is available
//   char_count  characters entered so far
//   preview     registered pattern of the current char_code
//   overflow    one-cycle pulse when a write is dropped because the buffer is full
//
// state     | meaning
// EMPTY     | no characters entered
// ENTRY     | 1..DEPTH-1 characters entered, writes accepted
// FULL      | DEPTH characters entered, writes dropped with overflow pulse
// COMMITTED | message published, buffer and length frozen until clear
// -----------------------------------------------------------------------------
module scroll_message_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic [4:0]        char_code,
    input  logic              write_n,
    input  logic              commit_n,
    input  logic              clear_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [6:0]        rd_pattern,
    output logic [ADDR_W:0]   msg_length,
    output logic              msg_valid,
    output logic [ADDR_W:0]   char_count,
    output logic [6:0]        preview,
    output logic              overflow
);

    typedef logic [ADDR_W:0] cnt_t;
    typedef enum logic [1:0] {EMPTY, ENTRY, FULL, COMMITTED} state_t;

    localparam cnt_t       CNT_LAST = cnt_t'(DEPTH - 1);
    localparam logic [6:0] BLANK    = 7'h7F;

    function automatic logic [6:0] encode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'b1000000;
            5'd1:    seg = 7'b1111001;
            5'd2:    seg = 7'b0100100;
            5'd3:    seg = 7'b0110000;
            5'd4:    seg = 7'b0011001;
            5'd5:    seg = 7'b0010010;
            5'd6:    seg = 7'b0000010;
            5'd7:    seg = 7'b1111000;
            5'd8:    seg = 7'b0000000;
            5'd9:    seg = 7'b0010000;
            5'd10:   seg = 7'b0001000;
            5'd11:   seg = 7'b0000011;
            5'd12:   seg = 7'b1000110;
            5'd13:   seg = 7'b0100001;
            5'd14:   seg = 7'b0000110;
            5'd15:   seg = 7'b0001110;
            5'd17:   seg = 7'b0001001;
            5'd18:   seg = 7'b1000111;
            5'd19:   seg = 7'b0001100;
            5'd20:   seg = 7'b1000001;
            5'd21:   seg = 7'b0111111;
            default: seg = BLANK;
        endcase
        return seg;
    endfunction

    // Key path: {clear, commit, write}. Synchronizer and edge registers reset
    // to 0 so a key held low through reset release never looks like a press.
    logic [2:0] key_s1_q, key_s2_q, key_prev_q;
    logic [2:0] key_press;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            key_s1_q   <= 3'b000;
            key_s2_q   <= 3'b000;
            key_prev_q <= 3'b000;
        end else begin
            key_s1_q   <= {clear_n, commit_n, write_n};
            key_s2_q   <= key_s1_q;
            key_prev_q <= key_s2_q;
        end
    end

    assign key_press = key_prev_q & ~key_s2_q;

    logic write_p, commit_p, clear_p;
    assign write_p  = key_press[0];
    assign commit_p = key_press[1];
    assign clear_p  = key_press[2];

    state_t     state_q;
    cnt_t       count_q;
    cnt_t       len_q;
    logic       valid_q;
    logic       ovf_q;
    logic [6:0] rd_pat_q;
    logic [6:0] preview_q;

    // Clear beats commit beats write; a write losing that race is simply lost.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= EMPTY;
            count_q <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (clear_p) begin
                state_q <= EMPTY;
                count_q <= '0;
                len_q   <= '0;
                valid_q <= 1'b0;
            end else if (commit_p) begin
                if (state_q == ENTRY || state_q == FULL) begin
                    len_q   <= count_q;
                    valid_q <= 1'b1;
                    state_q <= COMMITTED;
                end
            end else if (write_p) begin
                case (state_q)
                    EMPTY: begin
                        count_q <= cnt_t'(1);
                        state_q <= ENTRY;
                    end
                    ENTRY: begin
                        count_q <= count_q + cnt_t'(1);
                        if (count_q == CNT_LAST) begin
                            state_q <= FULL;
                        end
                    end
                    FULL:    ovf_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Buffer RAM: not reset, reads outside a committed message are masked.
    logic [6:0] mem [DEPTH];
    logic       mem_we;

    assign mem_we = write_p && !commit_p && !clear_p
                    && (state_q == EMPTY || state_q == ENTRY);

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[count_q[ADDR_W-1:0]] <= encode(char_code);
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rd_pat_q  <= BLANK;
            preview_q <= BLANK;
        end else begin
            preview_q <= encode(char_code);
            if (valid_q && ({1'b0, rd_addr} < len_q)) begin
                rd_pat_q <= mem[rd_addr];
            end else begin
                rd_pat_q <= BLANK;
            end
        end
    end

    assign rd_pattern = rd_pat_q;
    assign msg_length = len_q;
    assign msg_valid  = valid_q;
    assign char_count = count_q;
    assign preview    = preview_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_scroll_message_loader.sv
module tb_scroll_message_loader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clock = 1'b0;
    logic          resetb;
    logic [4:0]    char_code;
    logic          write_n, commit_n, clear_n;
    logic [AW-1:0] rd_addr;
    logic [6:0]    rd_pattern;
    logic [AW:0]   msg_length;
    logic          msg_valid;
    logic [AW:0]   char_count;
    logic [6:0]    preview;
    logic          overflow;

    scroll_message_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clock      (clock),
        .resetb     (resetb),
        .char_code  (char_code),
        .write_n    (write_n),
        .commit_n   (commit_n),
        .clear_n    (clear_n),
        .rd_addr    (rd_addr),
        .rd_pattern (rd_pattern),
        .msg_length (msg_length),
        .msg_valid  (msg_valid),
        .char_count (char_count),
        .preview    (preview),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: message as a list of character codes.
    logic [6:0] seg_tab [22];
    int  m_msg[$];
    bit  m_committed;
    int  m_len;

    function automatic int enc_m(input int code);
        if (code >= 0 && code <= 21) return int'(seg_tab[code]);
        return 'h7F;
    endfunction

    function automatic int exp_read(input int a);
        if (m_committed && a < m_len) return enc_m(m_msg[a]);
        return 'h7F;
    endfunction

    // Scoreboard: kind 0 rd_pattern, 1 preview, 2 char_count, 3 msg_length, 4 msg_valid
    typedef struct {
        int cyc;
        int kind;
        int exp;
    } sb_t;
    sb_t sb[$];
    int  ovf_exp[$];

    function automatic void push(input int kind, input int exp);
        sb_t e;
        e.cyc  = cyc + 1;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endfunction

    sb_t mon_e;
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            case (mon_e.kind)
                0:       chk("rd_pattern", int'(rd_pattern), mon_e.exp);
                1:       chk("preview",    int'(preview),    mon_e.exp);
                2:       chk("char_count", int'(char_count), mon_e.exp);
                3:       chk("msg_length", int'(msg_length), mon_e.exp);
                default: chk("msg_valid",  int'(msg_valid),  mon_e.exp);
            endcase
        end
        if (resetb && overflow) begin
            if (ovf_exp.size() == 0) chk("overflow_unexpected", 1, 0);
            else                     chk("overflow_cycle", cyc, ovf_exp.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_status();
        push(1, enc_m(int'(char_code)));
        push(2, m_msg.size());
        push(3, m_committed ? m_len : 0);
        push(4, m_committed ? 1 : 0);
        tick(1);
    endtask

    task automatic press(input bit w, input bit c, input bit cl, input int code);
        char_code = 5'(code);
        write_n   = ~w;
        commit_n  = ~c;
        clear_n   = ~cl;
        if (cl) begin
            m_msg.delete();
            m_committed = 0;
            m_len       = 0;
        end else if (c) begin
            if (!m_committed && m_msg.size() > 0) begin
                m_committed = 1;
                m_len       = m_msg.size();
            end
        end else if (w && !m_committed) begin
            if (m_msg.size() < DEPTH) m_msg.push_back(code);
            else                      ovf_exp.push_back(cyc + 3);
        end
        tick(3);
        write_n  = 1'b1;
        commit_n = 1'b1;
        clear_n  = 1'b1;
        tick(4);
    endtask

    task automatic rd(input int a);
        rd_addr = AW'(a);
        push(0, exp_read(a));
        tick(1);
    endtask

    task automatic reset_outputs_check(input string tag);
        chk({tag, "_rd_pattern"}, int'(rd_pattern), 'h7F);
        chk({tag, "_preview"},    int'(preview),    'h7F);
        chk({tag, "_char_count"}, int'(char_count), 0);
        chk({tag, "_msg_length"}, int'(msg_length), 0);
        chk({tag, "_msg_valid"},  int'(msg_valid),  0);
        chk({tag, "_overflow"},   int'(overflow),   0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                    7'h7F, 7'h09, 7'h47, 7'h0C, 7'h41, 7'h3F};
        m_committed = 0;
        m_len       = 0;
        resetb    = 1'b0;
        char_code = 5'd0;
        write_n   = 1'b1;
        commit_n  = 1'b1;
        clear_n   = 1'b1;
        rd_addr   = '0;
        tick(3);
        reset_outputs_check("por");
        resetb = 1'b1;
        tick(4);

        // Three characters then commit, read back with one-cycle latency.
        press(1, 0, 0, 0);
        press(1, 0, 0, 1);
        press(1, 0, 0, 10);
        press(0, 1, 0, 10);
        push_status();
        for (int a = 0; a < 4; a++) rd(a);

        // Fill past capacity: two dropped writes, then commit the full buffer.
        press(0, 0, 1, 0);
        for (int i = 0; i < DEPTH + 2; i++) press(1, 0, 0, int'($urandom_range(0, 21)));
        push_status();
        press(0, 1, 0, 3);
        push_status();
        rd(DEPTH - 1);
        rd(0);

        // Commit from an empty buffer does nothing.
        press(0, 0, 1, 5);
        press(0, 1, 0, 5);
        push_status();
        for (int a = 0; a < DEPTH; a++) rd(a);

        // Write and commit landing on the same edge: commit wins.
        press(1, 0, 0, 7);
        press(1, 0, 0, 8);
        press(1, 1, 0, 9);
        push_status();
        for (int a = 0; a < 3; a++) rd(a);

        // Reset in the middle of entry with write held across release.
        press(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) press(1, 0, 0, i + 2);
        push_status();
        #2;
        resetb  = 1'b0;
        write_n = 1'b0;
        #1;
        reset_outputs_check("midrst");
        m_msg.delete();
        m_committed = 0;
        m_len       = 0;
        tick(3);
        resetb = 1'b1;
        tick(6);
        write_n = 1'b1;
        tick(5);
        push_status();
        rd(0);

        // Committed message ignores writes; clear restarts entry.
        press(1, 0, 0, 17);
        press(0, 1, 0, 17);
        press(1, 0, 0, 4);
        push_status();
        press(0, 0, 1, 4);
        push_status();
        press(1, 0, 0, 21);
        push_status();
        press(0, 1, 0, 21);
        push_status();
        rd(0);
        rd(1);

        // Randomized key traffic.
        for (int i = 0; i < 150; i++) begin
            int r;
            int code;
            r    = int'($urandom_range(0, 99));
            code = int'($urandom_range(0, 31));
            if      (r < 66) press(1, 0, 0, code);
            else if (r < 78) press(0, 1, 0, code);
            else if (r < 82) press(0, 0, 1, code);
            else if (r < 88) press(1, 1, 0, code);
            else if (r < 92) press(1, 0, 1, code);
            else if (r < 95) press(0, 1, 1, code);
            else             press(1, 1, 1, code);
            push_status();
            if (i % 8 == 7) begin
                for (int j = 0; j < 6; j++) rd(int'($urandom_range(0, DEPTH - 1)));
            end
        end

        tick(3);
        chk("scoreboard_drained", sb.size(), 0);
        chk("overflow_missing", ovf_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
